// File: rtl/display_scheduler.sv
// display_scheduler
//   Owns the 16-bit word interface of the SPI master driving a MAX7219.
//   Runs the power-up init sequence, then shares the SPI master between
//   host intensity updates and per-tick digit-refresh frames. Digits are
//   snapshotted when a frame starts so a frame never tears.
//
//   Optional feature macro: DISPLAY_SCHED_DELTA_EN
//     When defined, per-digit shadow registers hold the last sent {dp,digit}
//     and a frame skips digits that have not changed.
//
// Ports
//   clk, res          clock, synchronous active-high reset
//   tick              frame request, rising edge detected internally
//   display_ena       ticks ignored while low
//   digit_data        BCD digit i at [4i+3:4i], digit 0 is address 1
//   dp_mask           decimal point per digit
//   int_req, int_val  intensity change request and value
//   int_ack           pulse when the intensity word has been sent
//   spi_word, spi_cs  word and active-low chip select to the SPI master
//   spi_send          SPI master report_send
//   spi_ready         SPI master report_ready
//   init_done         init sequence complete
//   busy              not IDLE
//   frame_drop        pulse when a tick is lost
module display_scheduler #(
  parameter int         DIGITS         = 6,
  parameter logic [7:0] SCAN_LIMIT     = 8'd5,
  parameter logic [3:0] INTENSITY_INIT = 4'h8
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  tick,
  input  logic                  display_ena,
  input  logic [4*DIGITS-1:0]   digit_data,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  int_req,
  input  logic [3:0]            int_val,
  output logic                  int_ack,
  output logic [15:0]           spi_word,
  output logic                  spi_cs,
  input  logic                  spi_send,
  input  logic                  spi_ready,
  output logic                  init_done,
  output logic                  busy,
  output logic                  frame_drop
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_SEND, S_WAIT_READY} state_t;
  typedef enum logic [1:0] {K_INIT, K_INT, K_FRAME} kind_t;

  state_t state, state_nx;
  kind_t  kind;

  logic [2:0]             init_idx;
  logic [IW-1:0]          digit_idx;
  logic                   frame_pend;     // set from tick until last digit done
  logic                   frame_started;  // snapshot taken for current frame
  logic                   int_pend;
  logic [3:0]             int_val_l;
  logic                   tick_q;
  logic [DIGITS-1:0][4:0] snap;

`ifdef DISPLAY_SCHED_DELTA_EN
  logic [DIGITS-1:0][4:0] shadow;
  logic [DIGITS-1:0]      shadow_vld;
`endif

  logic [DIGITS-1:0][3:0] dig_in;
  logic [DIGITS-1:0][4:0] cur_all;
  logic [4:0]             cur_dig;
  logic [15:0]            init_word, frame_word;
  logic                   tick_edge, sel_init, sel_int, sel_frame, skip, last_digit;

  assign dig_in     = digit_data;
  assign tick_edge  = tick & ~tick_q;
  assign sel_init   = ~init_done;
  assign sel_int    = init_done & int_pend;
  assign sel_frame  = init_done & ~int_pend & frame_pend;
  assign last_digit = (digit_idx == IW'(DIGITS - 1));
  assign busy       = (state != S_IDLE);

  always_comb begin
    cur_all = '0;
    for (int i = 0; i < DIGITS; i++) cur_all[i] = {dp_mask[i], dig_in[i]};
  end

  // First digit of a frame reads the live inputs, the same cycle they are
  // captured into snap; later digits read the snapshot.
  assign cur_dig    = frame_started ? snap[digit_idx] : cur_all[digit_idx];
  assign frame_word = {8'(digit_idx) + 8'd1, cur_dig[4], 3'b000, cur_dig[3:0]};

  always_comb begin
    case (init_idx)
      3'd0:    init_word = 16'h0C01;
      3'd1:    init_word = 16'h09FF;
      3'd2:    init_word = {8'h0B, SCAN_LIMIT};
      3'd3:    init_word = {8'h0A, 4'h0, INTENSITY_INIT};
      default: init_word = 16'h0F00;
    endcase
  end

`ifdef DISPLAY_SCHED_DELTA_EN
  assign skip = shadow_vld[digit_idx] && (shadow[digit_idx] == cur_dig);
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:       if (sel_init || sel_int || (sel_frame && !skip)) state_nx = S_ISSUE;
      S_ISSUE:      if (spi_ready) state_nx = S_WAIT_SEND;
      S_WAIT_SEND:  if (spi_send) state_nx = S_WAIT_READY;
      S_WAIT_READY: if (spi_ready && !spi_send) state_nx = S_IDLE;
      default:      state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state         <= S_IDLE;
      kind          <= K_INIT;
      init_idx      <= '0;
      digit_idx     <= '0;
      frame_pend    <= 1'b0;
      frame_started <= 1'b0;
      int_pend      <= 1'b0;
      int_val_l     <= '0;
      tick_q        <= 1'b0;
      snap          <= '0;
      spi_word      <= '0;
      spi_cs        <= 1'b1;
      int_ack       <= 1'b0;
      init_done     <= 1'b0;
      frame_drop    <= 1'b0;
`ifdef DISPLAY_SCHED_DELTA_EN
      shadow        <= '0;
      shadow_vld    <= '0;
`endif
    end else begin
      state      <= state_nx;
      tick_q     <= tick;
      int_ack    <= 1'b0;
      frame_drop <= 1'b0;

      // frame_pend covers both queued and in-progress frames, so a tick
      // during either is dropped rather than queued.
      if (tick_edge && display_ena) begin
        if (frame_pend) frame_drop <= 1'b1;
        else            frame_pend <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (sel_init) begin
            spi_word <= init_word;
            kind     <= K_INIT;
          end else if (sel_int) begin
            spi_word <= {8'h0A, 4'h0, int_val_l};
            kind     <= K_INT;
            int_pend <= 1'b0;
          end else if (sel_frame) begin
            if (!frame_started) begin
              snap          <= cur_all;
              frame_started <= 1'b1;
            end
            if (skip) begin
              // unchanged digit: advance without touching the SPI master
              if (last_digit) begin
                digit_idx     <= '0;
                frame_pend    <= 1'b0;
                frame_started <= 1'b0;
              end else begin
                digit_idx <= digit_idx + 1'b1;
              end
            end else begin
              spi_word <= frame_word;
              kind     <= K_FRAME;
`ifdef DISPLAY_SCHED_DELTA_EN
              shadow[digit_idx]     <= cur_dig;
              shadow_vld[digit_idx] <= 1'b1;
`endif
            end
          end
        end
        S_ISSUE: if (spi_ready) spi_cs <= 1'b0;
        S_WAIT_SEND: begin
          if (spi_send) begin
            spi_cs <= 1'b1;
            if (kind == K_INT) int_ack <= 1'b1;
          end
        end
        S_WAIT_READY: begin
          if (spi_ready && !spi_send) begin
            if (kind == K_INIT) begin
              if (init_idx == 3'd4) begin
                init_done <= 1'b1;
`ifdef DISPLAY_SCHED_DELTA_EN
                shadow_vld <= '0;
`endif
              end else begin
                init_idx <= init_idx + 3'd1;
              end
            end else if (kind == K_FRAME) begin
              if (last_digit) begin
                digit_idx     <= '0;
                frame_pend    <= 1'b0;
                frame_started <= 1'b0;
              end else begin
                digit_idx <= digit_idx + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase

      // A request landing on the same edge as the IDLE load wins, so it is
      // sent again rather than lost.
      if (int_req) begin
        int_pend  <= 1'b1;
        int_val_l <= int_val;
      end
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Testbench for display_scheduler: a randomised SPI master model, a
// scoreboard queue of expected words filled by a frame-level model, and a
// monitor that checks every word at chip-select fall.
module tb_display_scheduler;
  localparam int DIGITS = 6;
`ifdef DISPLAY_SCHED_DELTA_EN
  localparam bit DELTA = 1'b1;
`else
  localparam bit DELTA = 1'b0;
`endif

  logic clk = 1'b0;
  logic res = 1'b1;
  logic tick = 1'b0;
  logic display_ena = 1'b1;
  logic [4*DIGITS-1:0] digit_data = '0;
  logic [DIGITS-1:0] dp_mask = '0;
  logic int_req = 1'b0;
  logic [3:0] int_val = '0;
  logic int_ack, spi_cs, init_done, busy, frame_drop;
  logic [15:0] spi_word;
  logic spi_send = 1'b0;
  logic spi_ready = 1'b1;

  display_scheduler #(.DIGITS(DIGITS), .SCAN_LIMIT(8'd5), .INTENSITY_INIT(4'h8)) dut (
    .clk(clk), .res(res), .tick(tick), .display_ena(display_ena),
    .digit_data(digit_data), .dp_mask(dp_mask), .int_req(int_req),
    .int_val(int_val), .int_ack(int_ack), .spi_word(spi_word), .spi_cs(spi_cs),
    .spi_send(spi_send), .spi_ready(spi_ready), .init_done(init_done),
    .busy(busy), .frame_drop(frame_drop)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int words_seen = 0, acks_seen = 0, drops_seen = 0;
  int exp_acks = 0, exp_drops = 0;
  logic [15:0] exp_q[$];

  // reference model state: what the display currently shows
  logic [3:0] d_arr[DIGITS];
  logic       dp_arr[DIGITS];
  logic [4:0] last_val[DIGITS];
  bit         last_vld[DIGITS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h required %h", name, act, exp);
    end
  endtask

  function automatic void push_init();
    exp_q.push_back(16'h0C01);
    exp_q.push_back(16'h09FF);
    exp_q.push_back(16'h0B05);
    exp_q.push_back(16'h0A08);
    exp_q.push_back(16'h0F00);
    for (int i = 0; i < DIGITS; i++) last_vld[i] = 1'b0;
  endfunction

  // Expected words of one frame; an intensity word is slotted in after
  // ins_at frame words when ins_at > 0.
  function automatic void push_frame(input int ins_at, input logic [3:0] iv);
    int sent;
    logic [4:0] v;
    sent = 0;
    for (int i = 0; i < DIGITS; i++) begin
      v = {dp_arr[i], d_arr[i]};
      if (!DELTA || !last_vld[i] || last_val[i] != v) begin
        exp_q.push_back({8'(i + 1), v[4], 3'b000, v[3:0]});
        sent++;
        if (sent == ins_at) exp_q.push_back({8'h0A, 4'h0, iv});
        last_val[i] = v;
        last_vld[i] = 1'b1;
      end
    end
  endfunction

  task automatic apply_digits();
    for (int i = 0; i < DIGITS; i++) begin
      digit_data[4*i +: 4] = d_arr[i];
      dp_mask[i] = dp_arr[i];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_quiet(input int budget, input string name);
    int q, n;
    q = 0; n = 0;
    while (q < 8 && n < budget) begin
      step();
      n++;
      if (!busy && exp_q.size() == 0) q++; else q = 0;
    end
    if (q < 8) begin
      tests++; fails++;
      $display("FAIL %s timeout pending=%0d required 0", name, exp_q.size());
    end
  endtask

  task automatic wait_words(input int target, input string name);
    int n;
    n = 0;
    while (words_seen < target && n < 400) begin step(); n++; end
    if (words_seen < target) begin
      tests++; fails++;
      $display("FAIL %s words got %0d required %0d", name, words_seen, target);
    end
  endtask

  task automatic tick_pulse();
    tick = 1'b1; step(); step();
    tick = 1'b0; step(); step();
  endtask

  // SPI master model with random send/ready latencies
  initial begin
    int m_st, m_cnt;
    m_st = 0; m_cnt = 0;
    forever begin
      @(negedge clk);
      if (res) begin
        spi_ready = 1'b1; spi_send = 1'b0; m_st = 0;
      end else begin
        case (m_st)
          0: if (!spi_cs) begin spi_ready = 1'b0; m_cnt = $urandom_range(1, 4); m_st = 1; end
          1: if (m_cnt == 0) begin spi_send = 1'b1; m_st = 2; end else m_cnt--;
          2: begin spi_send = 1'b0; m_cnt = $urandom_range(0, 3); m_st = 3; end
          default: if (m_cnt == 0) begin spi_ready = 1'b1; m_st = 0; end else m_cnt--;
        endcase
      end
    end
  end

  // monitor: pop and compare at every chip-select fall
  initial begin
    logic prev_cs;
    logic [15:0] e;
    prev_cs = 1'b1;
    forever begin
      @(negedge clk);
      if (!res) begin
        if (prev_cs && !spi_cs) begin
          words_seen++;
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_word got %h required none", spi_word);
          end else begin
            e = exp_q.pop_front();
            chk("spi_word", {16'h0, spi_word}, {16'h0, e});
          end
        end
        if (int_ack) acks_seen++;
        if (frame_drop) drops_seen++;
      end
      prev_cs = spi_cs;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    logic [3:0] iv;

    // reset state
    repeat (3) step();
    chk("rst_cs", {31'h0, spi_cs}, 32'd1);
    chk("rst_word", {16'h0, spi_word}, 32'd0);
    chk("rst_ack", {31'h0, int_ack}, 32'd0);
    chk("rst_init_done", {31'h0, init_done}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_drop", {31'h0, frame_drop}, 32'd0);

    // init sequence
    push_init();
    res = 1'b0;
    wait_quiet(2000, "init");
    chk("init_done", {31'h0, init_done}, 32'd1);

    // directed frame: 3,9,5,4,1,2 with dp on digits 2 and 4
    d_arr = '{4'd3, 4'd9, 4'd5, 4'd4, 4'd1, 4'd2};
    dp_arr = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    apply_digits();
    push_frame(0, 4'h0);
    tick_pulse();
    wait_quiet(2000, "frame1");

    // intensity request while digit 2 is on the wire
    for (int i = 0; i < DIGITS; i++) begin d_arr[i] = (d_arr[i] + 4'd1) % 4'd10; dp_arr[i] = ~dp_arr[i]; end
    apply_digits();
    base = words_seen;
    push_frame(3, 4'hC);
    exp_acks++;
    tick = 1'b1;
    wait_words(base + 3, "int_wait");
    int_val = 4'hC; int_req = 1'b1;
    step();
    int_req = 1'b0; tick = 1'b0;
    wait_quiet(2000, "int_frame");
    chk("int_acks", acks_seen, exp_acks);

    // second tick during an active frame is dropped
    for (int i = 0; i < DIGITS; i++) d_arr[i] = (d_arr[i] + 4'd1) % 4'd10;
    apply_digits();
    base = words_seen;
    push_frame(0, 4'h0);
    tick = 1'b1;
    wait_words(base + 1, "drop_wait");
    tick = 1'b0; step(); step();
    tick = 1'b1; exp_drops++; step();
    tick = 1'b0;
    wait_quiet(2000, "drop_frame");
    chk("drops", drops_seen, exp_drops);

    // tick ignored while display disabled
    display_ena = 1'b0;
    for (int i = 0; i < DIGITS; i++) d_arr[i] = (d_arr[i] + 4'd3) % 4'd10;
    apply_digits();
    base = words_seen;
    tick_pulse();
    wait_quiet(200, "disabled");
    chk("disabled_words", words_seen - base, 0);
    chk("disabled_drops", drops_seen, exp_drops);
    display_ena = 1'b1;

    // enabled frame with the new digits, then only digit 0 changed, then none
    push_frame(0, 4'h0);
    tick_pulse();
    wait_quiet(2000, "refresh");
    d_arr[0] = (d_arr[0] + 4'd1) % 4'd10;
    apply_digits();
    base = words_seen;
    push_frame(0, 4'h0);
    tick_pulse();
    wait_quiet(2000, "one_changed");
    chk("one_changed_words", words_seen - base, DELTA ? 1 : DIGITS);
    base = words_seen;
    push_frame(0, 4'h0);
    tick_pulse();
    wait_quiet(2000, "unchanged");
    chk("unchanged_words", words_seen - base, DELTA ? 0 : DIGITS);

    // randomised frames, sometimes preceded by an intensity request
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < DIGITS; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          d_arr[i] = 4'($urandom_range(0, 9));
          dp_arr[i] = 1'($urandom_range(0, 1));
        end
      end
      apply_digits();
      if ($urandom_range(0, 2) == 0) begin
        iv = 4'($urandom_range(0, 15));
        exp_q.push_back({8'h0A, 4'h0, iv});
        exp_acks++;
        int_val = iv; int_req = 1'b1;
        step();
        int_req = 1'b0;
      end
      push_frame(0, 4'h0);
      tick_pulse();
      wait_quiet(2000, "rand_frame");
    end
    chk("rand_acks", acks_seen, exp_acks);

    // reset mid-word restarts init
    for (int i = 0; i < DIGITS; i++) d_arr[i] = (d_arr[i] + 4'd1) % 4'd10;
    apply_digits();
    push_frame(0, 4'h0);
    tick = 1'b1;
    n = 0;
    while (spi_cs && n < 400) begin step(); n++; end
    chk("pre_reset_cs", {31'h0, spi_cs}, 32'd0);
    res = 1'b1;
    @(posedge clk); #1;
    chk("reset_cs", {31'h0, spi_cs}, 32'd1);
    chk("reset_busy", {31'h0, busy}, 32'd0);
    chk("reset_init_done", {31'h0, init_done}, 32'd0);
    tick = 1'b0;
    exp_q.delete();
    step(); step();
    push_init();
    res = 1'b0;
    wait_quiet(2000, "reinit");
    chk("reinit_done", {31'h0, init_done}, 32'd1);
    push_frame(0, 4'h0);
    tick_pulse();
    wait_quiet(2000, "post_reset_frame");
    chk("final_acks", acks_seen, exp_acks);
    chk("final_drops", drops_seen, exp_drops);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
